// File: rtl/axi_inf_pkg.sv
// Shared constants, FSM state type and sizing helper for the AXI write responder.
package axi_inf_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } wr_state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axi_inf_write_slave_core_if.sv
// AW/W/B channels plus the local memory write port of the write responder.
interface axi_inf_write_slave_core_if #(
  parameter int IDSIZE = 3,
  parameter int LSIZE  = 8,
  parameter int ASIZE  = 32,
  parameter int DSIZE  = 256
);
  logic [IDSIZE-1:0]  axi_awid;
  logic [ASIZE-1:0]   axi_awaddr;
  logic [LSIZE-1:0]   axi_awlen;
  logic [2:0]         axi_awsize;
  logic [1:0]         axi_awburst;
  logic               axi_awvalid;
  logic               axi_awready;
  logic [DSIZE-1:0]   axi_wdata;
  logic [DSIZE/8-1:0] axi_wstrb;
  logic               axi_wlast;
  logic               axi_wvalid;
  logic               axi_wready;
  logic [IDSIZE-1:0]  axi_bid;
  logic [1:0]         axi_bresp;
  logic               axi_bvalid;
  logic               axi_bready;
  logic               mem_wr_en;
  logic [ASIZE-1:0]   mem_wr_addr;
  logic [DSIZE-1:0]   mem_wr_data;
  logic [DSIZE/8-1:0] mem_wr_strb;
  logic               mem_wr_rdy;

  modport slave (
    input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
    input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, axi_bready, mem_wr_rdy,
    output axi_awready, axi_wready, axi_bid, axi_bresp, axi_bvalid,
    output mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_strb
  );

  modport master (
    output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
    output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, axi_bready, mem_wr_rdy,
    input  axi_awready, axi_wready, axi_bid, axi_bresp, axi_bvalid,
    input  mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_strb
  );
endinterface

// File: rtl/axi_inf_wr_addr_gen.sv
// Per-beat byte address and beat counter for an INCR burst; shareable with the read responder.
module axi_inf_wr_addr_gen #(
  parameter int ASIZE = 32,
  parameter int LSIZE = 8
) (
  input  logic             axi_aclk,
  input  logic             axi_resetn,
  input  logic             load,
  input  logic             step,
  input  logic [ASIZE-1:0] start_addr,
  input  logic [2:0]       size,
  output logic [ASIZE-1:0] addr,
  output logic [LSIZE-1:0] beat_cnt
);
  logic [ASIZE-1:0] addr_reg;
  logic [2:0]       size_reg;
  logic [LSIZE-1:0] beat_reg;

  // Address wraps modulo 2**ASIZE; no 4 KB boundary handling.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      addr_reg <= '0;
      size_reg <= '0;
      beat_reg <= '0;
    end else if (load) begin
      addr_reg <= start_addr;
      size_reg <= size;
      beat_reg <= '0;
    end else if (step) begin
      addr_reg <= addr_reg + (ASIZE'(1) << size_reg);
      beat_reg <= beat_reg + LSIZE'(1);
    end
  end

  assign addr     = addr_reg;
  assign beat_cnt = beat_reg;
endmodule

// File: rtl/axi_inf_write_slave_core.sv
// AXI4 single-outstanding write responder forwarding beats to a local write port.
// Optional wlast consistency check: define AXI_WR_SLAVE_WLAST_CHECK_EN.
module axi_inf_write_slave_core
  import axi_inf_pkg::*;
#(
  parameter int IDSIZE = 3,
  parameter int LSIZE  = 8,
  parameter int ASIZE  = 32,
  parameter int DSIZE  = 256
) (
  input  logic                       axi_aclk,
  input  logic                       axi_resetn,
  axi_inf_write_slave_core_if.slave  bus,
  output logic                       burst_done,
  output logic                       burst_err
);
  localparam logic [2:0] MAX_SIZE = 3'(clog2(DSIZE / 8));

  wr_state_t         state_reg;
  logic              awready_reg;
  logic              bvalid_reg;
  logic [IDSIZE-1:0] bid_reg;
  logic [1:0]        bresp_reg;
  logic [LSIZE-1:0]  len_reg;
  logic              err_cmd_reg;
  logic              err_last_reg;

  logic              aw_fire;
  logic              wready;
  logic              beat;
  logic              final_beat;
  logic              last_bad;
  logic [ASIZE-1:0]  beat_addr;
  logic [LSIZE-1:0]  beat_cnt;

  assign aw_fire    = (state_reg == ST_IDLE) && bus.axi_awvalid && awready_reg;
  assign wready     = (state_reg == ST_DATA) && bus.mem_wr_rdy;
  assign beat       = wready && bus.axi_wvalid;
  assign final_beat = (beat_cnt == len_reg);

`ifdef AXI_WR_SLAVE_WLAST_CHECK_EN
  assign last_bad = beat && (bus.axi_wlast != final_beat);
`else
  logic unused_wlast;
  assign last_bad     = 1'b0;
  assign unused_wlast = bus.axi_wlast;
`endif

  axi_inf_wr_addr_gen #(
    .ASIZE (ASIZE),
    .LSIZE (LSIZE)
  ) u_addr_gen (
    .axi_aclk   (axi_aclk),
    .axi_resetn (axi_resetn),
    .load       (aw_fire),
    .step       (beat),
    .start_addr (bus.axi_awaddr),
    .size       (bus.axi_awsize),
    .addr       (beat_addr),
    .beat_cnt   (beat_cnt)
  );

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_reg    <= ST_IDLE;
      awready_reg  <= 1'b0;
      bvalid_reg   <= 1'b0;
      bid_reg      <= '0;
      bresp_reg    <= RESP_OKAY;
      len_reg      <= '0;
      err_cmd_reg  <= 1'b0;
      err_last_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          awready_reg <= 1'b1;
          if (aw_fire) begin
            awready_reg  <= 1'b0;
            bid_reg      <= bus.axi_awid;
            len_reg      <= bus.axi_awlen;
            err_cmd_reg  <= (bus.axi_awburst != BURST_INCR) || (bus.axi_awsize > MAX_SIZE);
            err_last_reg <= 1'b0;
            state_reg    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat) begin
            err_last_reg <= err_last_reg | last_bad;
            // Count-based termination: wlast never ends or extends the burst.
            if (final_beat) begin
              bvalid_reg <= 1'b1;
              bresp_reg  <= (err_cmd_reg || err_last_reg || last_bad) ? RESP_SLVERR : RESP_OKAY;
              state_reg  <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (bus.axi_bready) begin
            bvalid_reg   <= 1'b0;
            awready_reg  <= 1'b1;
            err_last_reg <= 1'b0;
            state_reg    <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.axi_awready = awready_reg;
  assign bus.axi_wready  = wready;
  assign bus.axi_bvalid  = bvalid_reg;
  assign bus.axi_bid     = bid_reg;
  assign bus.axi_bresp   = bresp_reg;

  // Bad-command bursts still drain their beats but never reach memory.
  assign bus.mem_wr_en   = beat && !err_cmd_reg;
  assign bus.mem_wr_addr = beat_addr;
  assign bus.mem_wr_data = bus.axi_wdata;
  assign bus.mem_wr_strb = bus.axi_wstrb;

  assign burst_done = bvalid_reg && bus.axi_bready;
  assign burst_err  = burst_done && (bresp_reg == RESP_SLVERR);
endmodule

// File: tb/tb_axi_inf_write_slave_core.sv
// Directed plus randomized bursts checked against a per-burst expected-write model.
module tb_axi_inf_write_slave_core;
  localparam int IDSIZE = 3;
  localparam int LSIZE  = 8;
  localparam int ASIZE  = 32;
  localparam int DSIZE  = 256;
  localparam int SW     = DSIZE / 8;

  logic axi_aclk   = 1'b0;
  logic axi_resetn = 1'b0;
  logic burst_done;
  logic burst_err;

  always #5 axi_aclk = ~axi_aclk;

  axi_inf_write_slave_core_if #(
    .IDSIZE(IDSIZE), .LSIZE(LSIZE), .ASIZE(ASIZE), .DSIZE(DSIZE)
  ) bus ();

  axi_inf_write_slave_core #(
    .IDSIZE(IDSIZE), .LSIZE(LSIZE), .ASIZE(ASIZE), .DSIZE(DSIZE)
  ) dut (
    .axi_aclk   (axi_aclk),
    .axi_resetn (axi_resetn),
    .bus        (bus),
    .burst_done (burst_done),
    .burst_err  (burst_err)
  );

  typedef struct {
    logic [ASIZE-1:0] addr;
    logic [DSIZE-1:0] data;
    logic [SW-1:0]    strb;
  } wr_t;

  wr_t obs_q[$];
  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  done_cnt = 0;
  int  err_cnt  = 0;

  always @(negedge axi_aclk) begin
    if (bus.mem_wr_en === 1'b1) obs_q.push_back('{bus.mem_wr_addr, bus.mem_wr_data, bus.mem_wr_strb});
    if (burst_done === 1'b1) done_cnt++;
    if (burst_err === 1'b1) err_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DSIZE-1:0] rand_data();
    logic [DSIZE-1:0] d;
    for (int i = 0; i < DSIZE / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  // wl_mode 0: wlast on the final beat; 1: wlast only on beat 1.
  // rdy_mode 0: always ready; 1: 1,0,0,1 pattern; 2: random.
  task automatic run_burst(input logic [IDSIZE-1:0] id, input logic [ASIZE-1:0] addr,
                           input logic [LSIZE-1:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int wl_mode, input int rdy_mode,
                           input bit hold_aw);
    bit         err_cmd;
    bit         wl_bad;
    bit         exp_err;
    int         beat;
    int         cyc;
    int         bdelay;
    int         done0;
    int         err0;
    logic       rdy;
    logic       wl;
    logic [1:0] exp_resp;

    err_cmd = (burst != 2'b01) || (size > 3'd5);
    wl_bad  = 1'b0;
    obs_q.delete();
    exp_q.delete();
    done0 = done_cnt;
    err0  = err_cnt;

    @(posedge axi_aclk); #1;
    bus.axi_awid    = id;
    bus.axi_awaddr  = addr;
    bus.axi_awlen   = len;
    bus.axi_awsize  = size;
    bus.axi_awburst = burst;
    bus.axi_awvalid = 1'b1;
    cyc = 0;
    do begin
      @(negedge axi_aclk);
      cyc++;
    end while (bus.axi_awready !== 1'b1 && cyc < 20);
    check("aw_accept", bus.axi_awready, 1'b1);
    if (bus.axi_awready !== 1'b1) return;
    @(posedge axi_aclk); #1;
    bus.axi_awvalid = hold_aw;

    beat = 0;
    cyc  = 0;
    bus.axi_wvalid = 1'b1;
    bus.axi_wdata  = rand_data();
    bus.axi_wstrb  = SW'($urandom());
    while (beat <= int'(len) && cyc < 300) begin
      wl = (wl_mode == 1) ? (beat == 1) : (beat == int'(len));
      bus.axi_wlast = wl;
      case (rdy_mode)
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        2:       rdy = 1'($urandom_range(0, 1));
        default: rdy = 1'b1;
      endcase
      bus.mem_wr_rdy = rdy;
      @(negedge axi_aclk);
      check("wready", bus.axi_wready, rdy);
      check("awready_busy", bus.axi_awready, 1'b0);
      check("bvalid_busy", bus.axi_bvalid, 1'b0);
      check("mem_wr_en", bus.mem_wr_en, rdy & ~err_cmd);
      if (rdy) begin
        if (!err_cmd)
          exp_q.push_back('{ASIZE'(addr + ASIZE'(beat) * (ASIZE'(1) << size)),
                            bus.axi_wdata, bus.axi_wstrb});
        if (wl != (beat == int'(len))) wl_bad = 1'b1;
      end
      @(posedge axi_aclk); #1;
      if (rdy) begin
        beat++;
        bus.axi_wdata = rand_data();
        bus.axi_wstrb = SW'($urandom());
      end
      cyc++;
    end
    check("w_beats", beat, int'(len) + 1);
    bus.axi_wvalid  = 1'b0;
    bus.axi_wlast   = 1'b0;
    bus.axi_awvalid = 1'b0;

`ifdef AXI_WR_SLAVE_WLAST_CHECK_EN
    exp_err = err_cmd || wl_bad;
`else
    exp_err = err_cmd;
`endif
    exp_resp = exp_err ? 2'b10 : 2'b00;

    @(negedge axi_aclk);
    check("bvalid", bus.axi_bvalid, 1'b1);
    check("bid", bus.axi_bid, id);
    check("bresp", bus.axi_bresp, exp_resp);
    bdelay = $urandom_range(0, 2);
    for (int i = 0; i < bdelay; i++) begin
      @(posedge axi_aclk); #1;
      @(negedge axi_aclk);
      check("bvalid_hold", bus.axi_bvalid, 1'b1);
      check("done_idle", burst_done, 1'b0);
    end
    @(posedge axi_aclk); #1;
    bus.axi_bready = 1'b1;
    @(negedge axi_aclk);
    check("burst_done", burst_done, 1'b1);
    check("burst_err", burst_err, exp_err);
    @(posedge axi_aclk); #1;
    bus.axi_bready = 1'b0;
    @(negedge axi_aclk);
    check("awready_after_b", bus.axi_awready, 1'b1);
    check("bvalid_after_b", bus.axi_bvalid, 1'b0);
    check("done_pulse_once", done_cnt - done0, 1);
    check("err_pulse_count", err_cnt - err0, exp_err ? 1 : 0);
    check("wr_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check("wr_addr", obs_q[i].addr, exp_q[i].addr);
      check("wr_data", obs_q[i].data, exp_q[i].data);
      check("wr_strb", obs_q[i].strb, exp_q[i].strb);
    end
    $display("burst id=%0d addr=%08h len=%0d size=%0d burst=%0d writes=%0d bresp=%0d",
             id, addr, len, size, burst, obs_q.size(), bus.axi_bresp);
  endtask

  initial begin
    bus.axi_awid    = '0;
    bus.axi_awaddr  = '0;
    bus.axi_awlen   = '0;
    bus.axi_awsize  = '0;
    bus.axi_awburst = '0;
    bus.axi_awvalid = 1'b0;
    bus.axi_wdata   = '0;
    bus.axi_wstrb   = '0;
    bus.axi_wlast   = 1'b0;
    bus.axi_wvalid  = 1'b0;
    bus.axi_bready  = 1'b0;
    bus.mem_wr_rdy  = 1'b1;

    repeat (3) @(posedge axi_aclk);
    @(negedge axi_aclk);
    check("rst_awready", bus.axi_awready, 1'b0);
    check("rst_wready", bus.axi_wready, 1'b0);
    check("rst_bvalid", bus.axi_bvalid, 1'b0);
    check("rst_bresp", bus.axi_bresp, 2'b00);
    check("rst_bid", bus.axi_bid, 3'd0);
    check("rst_mem_wr_en", bus.mem_wr_en, 1'b0);
    check("rst_burst_done", burst_done, 1'b0);
    check("rst_burst_err", burst_err, 1'b0);
    @(posedge axi_aclk); #1;
    axi_resetn = 1'b1;
    @(negedge axi_aclk);
    check("awready_pre_edge", bus.axi_awready, 1'b0);
    @(negedge axi_aclk);
    check("awready_first_edge", bus.axi_awready, 1'b1);

    run_burst(3'd3, 32'h0000_1000, 8'd0, 3'd5, 2'b01, 0, 0, 1'b0);
    run_burst(3'd1, 32'h0000_2000, 8'd3, 3'd5, 2'b01, 0, 0, 1'b1);
    run_burst(3'd2, 32'h0000_3000, 8'd1, 3'd5, 2'b01, 0, 1, 1'b0);
    run_burst(3'd4, 32'h0000_4000, 8'd2, 3'd5, 2'b10, 0, 0, 1'b0);
    run_burst(3'd5, 32'hFFFF_FFE0, 8'd1, 3'd5, 2'b01, 0, 0, 1'b0);
    run_burst(3'd6, 32'h0000_5000, 8'd2, 3'd5, 2'b01, 1, 0, 1'b0);
    run_burst(3'd7, 32'h0000_6000, 8'd1, 3'd6, 2'b01, 0, 2, 1'b0);

    for (int n = 0; n < 20; n++) begin
      logic [1:0] bt;
      bt = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      run_burst(IDSIZE'($urandom()), ASIZE'($urandom()), LSIZE'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), bt, 0, 2, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a burst: no response, clean restart.
    begin
      int done0;
      done0 = done_cnt;
      @(posedge axi_aclk); #1;
      bus.axi_awid    = 3'd2;
      bus.axi_awaddr  = 32'h0000_7000;
      bus.axi_awlen   = 8'd3;
      bus.axi_awsize  = 3'd5;
      bus.axi_awburst = 2'b01;
      bus.axi_awvalid = 1'b1;
      @(negedge axi_aclk);
      check("rst_test_aw", bus.axi_awready, 1'b1);
      @(posedge axi_aclk); #1;
      bus.axi_awvalid = 1'b0;
      bus.axi_wvalid  = 1'b1;
      bus.mem_wr_rdy  = 1'b1;
      @(posedge axi_aclk); #1;
      axi_resetn = 1'b0;
      @(negedge axi_aclk);
      check("midrst_bvalid", bus.axi_bvalid, 1'b0);
      check("midrst_awready", bus.axi_awready, 1'b0);
      check("midrst_wready", bus.axi_wready, 1'b0);
      repeat (2) @(posedge axi_aclk);
      #1;
      axi_resetn     = 1'b1;
      bus.axi_wvalid = 1'b0;
      @(negedge axi_aclk);
      check("rel_awready_pre", bus.axi_awready, 1'b0);
      @(negedge axi_aclk);
      check("rel_awready", bus.axi_awready, 1'b1);
      check("rel_bvalid", bus.axi_bvalid, 1'b0);
      repeat (3) @(negedge axi_aclk);
      check("midrst_no_done", done_cnt - done0, 0);
      $display("reset mid-burst: awready=%0d bvalid=%0d", bus.axi_awready, bus.axi_bvalid);
    end

    run_burst(3'd1, 32'h0000_8000, 8'd2, 3'd4, 2'b01, 0, 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
